// File: rtl/bram_pkg.sv
// Shared types and constants for the simple-dual-port block RAM.
//   ctrl_state_t : clear-sequencer states
//   RDW_OLD/NEW  : read-during-write policy selectors for RDW_MODE
package bram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ctrl_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/bram_clear_ctrl.sv
// Clear sequencer: sweeps every address of the RAM once, one word per cycle.
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : start request, sampled only while idle
//   busy         : registered, high for exactly 2**ADDR_WIDTH cycles per sweep
//   sweep_we     : write strobe for the sweep port
//   sweep_addr   : address being cleared this cycle
//
// state | meaning
// IDLE  | waiting for clear; RAM ports owned by the user
// CLEAR | writing the clear value to address cnt, one per cycle
module bram_clear_ctrl
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    output logic                  busy,
    output logic                  sweep_we,
    output logic [ADDR_WIDTH-1:0] sweep_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    ctrl_state_t           state;
    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (clear) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign sweep_we   = busy;
    assign sweep_addr = cnt;

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port block RAM with per-byte write masks, selectable
// read-during-write behaviour, 1- or 2-stage read pipeline and a clear sweep.
//   clk, rst        : clock, asynchronous active-high reset (memory not reset)
//   clear, busy     : start clear sweep / sweep in progress
//   wrEn, wrAddr,
//   wrMask, wrData  : write port, wrMask bit i enables byte lane i
//   rdEn, rdAddr    : read request
//   rdData, rdValid : read result, rdData holds its value while rdValid is low
module bram_sdp
    import bram_pkg::*;
#(
    parameter int                       ADDR_WIDTH   = 8,
    parameter int                       DATA_WIDTH   = 16,
    parameter int                       BYTE_WIDTH   = 8,
    parameter int                       READ_LATENCY = 1,
    parameter int                       RDW_MODE     = RDW_OLD,
    parameter logic [DATA_WIDTH-1:0]    CLEAR_VALUE  = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    output logic                              busy,
    input  logic                              wrEn,
    input  logic [ADDR_WIDTH-1:0]             wrAddr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]  wrMask,
    input  logic [DATA_WIDTH-1:0]             wrData,
    input  logic                              rdEn,
    input  logic [ADDR_WIDTH-1:0]             rdAddr,
    output logic [DATA_WIDTH-1:0]             rdData,
    output logic                              rdValid
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;

    bram_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // Sweep owns the write port while busy; user requests are dropped.
    logic [NUM_BYTES-1:0]  lane_we;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;

    always_comb begin
        lane_we = '0;
        wa      = wrAddr;
        wd      = wrData;
        if (sweep_we) begin
            lane_we = '1;
            wa      = sweep_addr;
            wd      = CLEAR_VALUE;
        end else if (wrEn) begin
            lane_we = wrMask;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (lane_we[i]) begin
                mem[wa][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read side: the array read returns the pre-write word; in new-data mode
    // the lanes being written to the same address are forwarded from wrData.
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_word;

    assign rd_fire = rdEn & ~busy;

    always_comb begin
        rd_word = mem[rdAddr];
        if (RDW_MODE == RDW_NEW && wrEn && !busy && wrAddr == rdAddr) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wrMask[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wrData[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd1_q;
    logic                  v1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= rd_fire;
            if (rd_fire) begin
                rd1_q <= rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd2_q;
            logic                  v2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd2_q <= '0;
                    v2_q  <= 1'b0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        rd2_q <= rd1_q;
                    end
                end
            end

            assign rdData  = rd2_q;
            assign rdValid = v2_q;
        end else begin : g_lat1
            assign rdData  = rd1_q;
            assign rdValid = v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp.sv
module tb_bram_sdp;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [1:0]    wrMask;
    logic [DW-1:0] wrData;
    logic          rdEn;
    logic [AW-1:0] rdAddr;

    logic          busy0, busy1, rdValid0, rdValid1;
    logic [DW-1:0] rdData0, rdData1;

    always #5 clk = ~clk;

    // dut0: latency 1, old data on collision; dut1: latency 2, new data.
    bram_sdp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_VALUE(16'h0000)
    ) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy0),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrMask(wrMask), .wrData(wrData),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData0), .rdValid(rdValid0)
    );

    bram_sdp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_VALUE(16'h0000)
    ) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy1),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrMask(wrMask), .wrData(wrData),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData1), .rdValid(rdValid1)
    );

    // Reference model
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rd_t;

    logic [DW-1:0] mem_m [NW];
    rd_t           q0 [$];
    rd_t           q1 [$];
    logic [DW-1:0] last0, last1;
    int            clear_left;
    int            cyc;
    int            errors;
    int            checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [1:0] m);
        logic [DW-1:0] r;
        r = old;
        if (m[0]) r[7:0]  = d[7:0];
        if (m[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    task automatic check_outputs();
        logic v0, v1;
        v0 = 1'b0;
        v1 = 1'b0;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            v0 = 1'b1;
            last0 = q0[0].d;
            void'(q0.pop_front());
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            v1 = 1'b1;
            last1 = q1[0].d;
            void'(q1.pop_front());
        end
        chk("busy0",    {31'd0, busy0},    {31'd0, clear_left > 0});
        chk("busy1",    {31'd0, busy1},    {31'd0, clear_left > 0});
        chk("rdValid0", {31'd0, rdValid0}, {31'd0, v0});
        chk("rdValid1", {31'd0, rdValid1}, {31'd0, v1});
        chk("rdData0",  {16'd0, rdData0},  {16'd0, last0});
        chk("rdData1",  {16'd0, rdData1},  {16'd0, last1});
    endtask

    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [1:0] wm,
                         input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                         input logic clr);
        logic [DW-1:0] old_w;
        @(negedge clk);
        check_outputs();
        wrEn = we; wrAddr = wa; wrMask = wm; wrData = wd;
        rdEn = re; rdAddr = ra; clear = clr;
        if (clear_left > 0) begin
            mem_m[NW - clear_left] = 16'h0000;
            clear_left--;
        end else begin
            if (re) begin
                old_w = mem_m[ra];
                q0.push_back('{due: cyc + 1, d: old_w});
                q1.push_back('{due: cyc + 2, d: (we && wa == ra) ? merge(old_w, wd, wm) : old_w});
            end
            if (we) mem_m[wa] = merge(mem_m[wa], wd, wm);
            if (clr) clear_left = NW;
        end
        cyc++;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
        cycle(1'b1, a, m, d, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cycle(1'b0, '0, 2'b00, '0, 1'b1, a, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 2'b00, '0, 1'b0, '0, 1'b0);
    endtask

    // Reset asserted in the middle of a cycle; busy must fall without a clock edge.
    task automatic mid_reset();
        @(negedge clk);
        check_outputs();
        wrEn = 1'b0; rdEn = 1'b0; clear = 1'b0; wrMask = 2'b00;
        rst = 1'b1;
        #1;
        chk("rst_busy0",    {31'd0, busy0},    32'd0);
        chk("rst_busy1",    {31'd0, busy1},    32'd0);
        chk("rst_rdValid0", {31'd0, rdValid0}, 32'd0);
        chk("rst_rdValid1", {31'd0, rdValid1}, 32'd0);
        clear_left = 0;
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc += 2;
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; clear_left = 0;
        last0 = '0; last1 = '0;
        rst = 1'b1; clear = 1'b0; wrEn = 1'b0; wrAddr = '0; wrMask = '0;
        wrData = '0; rdEn = 1'b0; rdAddr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Known contents everywhere before any read
        for (int a = 0; a < NW; a++) wr(a[AW-1:0], 16'($urandom), 2'b11);

        // Full write then read next cycle
        wr(4'd3, 16'hBEEF, 2'b11);
        rd(4'd3);
        idle(3);

        // Byte masks, including an empty mask
        wr(4'd5, 16'h1234, 2'b11);
        wr(4'd5, 16'hABCD, 2'b01);
        rd(4'd5);
        wr(4'd5, 16'hABCD, 2'b00);
        rd(4'd5);
        wr(4'd5, 16'h5A00, 2'b10);
        rd(4'd5);
        idle(3);

        // Same-address read and write in one cycle, full and partial masks
        wr(4'd7, 16'h1111, 2'b11);
        cycle(1'b1, 4'd7, 2'b11, 16'h2222, 1'b1, 4'd7, 1'b0);
        cycle(1'b1, 4'd7, 2'b10, 16'h3344, 1'b1, 4'd7, 1'b0);
        cycle(1'b1, 4'd8, 2'b11, 16'h9999, 1'b1, 4'd7, 1'b0);
        idle(3);

        // Back-to-back reads
        wr(4'd1, 16'h0001, 2'b11);
        wr(4'd2, 16'h0002, 2'b11);
        wr(4'd3, 16'h0003, 2'b11);
        rd(4'd1);
        rd(4'd2);
        rd(4'd3);
        idle(3);

        // Full clear with reads attempted throughout, write in the start cycle
        for (int a = 0; a < NW; a++) wr(a[AW-1:0], 16'hFFFF, 2'b11);
        rd(4'd9);
        cycle(1'b1, 4'd9, 2'b11, 16'h4321, 1'b1, 4'd9, 1'b1);
        for (int i = 0; i < NW; i++) cycle(1'b1, 4'd2, 2'b11, 16'h7777, 1'b1, i[AW-1:0], 1'b1);
        for (int a = 0; a < NW; a++) rd(a[AW-1:0]);
        idle(3);

        // Reset during the fifth busy cycle
        for (int a = 0; a < NW; a++) wr(a[AW-1:0], 16'hFFFF, 2'b11);
        cycle(1'b0, '0, 2'b00, '0, 1'b0, '0, 1'b1);
        idle(4);
        mid_reset();
        for (int a = 0; a < NW; a++) rd(a[AW-1:0]);
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 39) == 0));
        end
        idle(NW + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_sdp.md
# bram_sdp

Parametrised simple-dual-port block RAM with one write port and one read port. Adds per-byte write masks, a selectable read-during-write policy, a one- or two-stage read pipeline with a valid flag, and a hardware clear sequencer that sweeps every word to a constant. Serves as the generic storage primitive for WFA wavefront and traceback buffers. Synthesises to inferred BRAM plus a small controller.

## Interface
- ADDR_WIDTH, 8, word address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-mask lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
- READ_LATENCY, 1, 1 or 2 cycles from rdEn to rdData
- RDW_MODE, 0, 0 = old data on same-address read/write, 1 = new (mask-merged) data
- CLEAR_VALUE, '0, DATA_WIDTH value written by the clear sweep

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  start clear sweep (level sampled in IDLE)
- busy  out  1  high while sweep in progress
- wrEn  in  1  write request
- wrAddr  in  ADDR_WIDTH  write address
- wrMask  in  NUM_BYTES  per-byte write enable, bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- wrData  in  DATA_WIDTH  write data
- rdEn  in  1  read request
- rdAddr  in  ADDR_WIDTH  read address
- rdData  out  DATA_WIDTH  read data
- rdValid  out  1  rdData carries result of a read

## Operation
- Controller states: IDLE, CLEAR. rst -> IDLE, sweep counter 0.
- IDLE: clear=1 -> CLEAR next cycle. wrEn writes masked lanes of wrData to wrAddr. rdEn issues a read.
- CLEAR: write CLEAR_VALUE (all lanes) to address = counter, counter++ each cycle; after address 2**ADDR_WIDTH-1 -> IDLE, counter 0.
- busy = (state == CLEAR); registered.
- While busy: wrEn, rdEn and clear ignored; no rdValid generated from requests during busy.
- clear and wrEn in the same IDLE cycle: user write performed; sweep then overwrites it.
- Read and write to the same address in one cycle: RDW_MODE 0 returns pre-write word; RDW_MODE 1 returns word with masked lanes replaced by wrData, unmasked lanes old.
- Reads/writes to different addresses in one cycle: fully independent.
- wrMask = 0 with wrEn = 1: no change to memory.
- Memory array is not reset by rst; contents persist except as overwritten.

## Timing
- Reset values: busy 0, rdValid 0, rdData 0, pipeline valid bits 0.
- READ_LATENCY 1: rdEn at cycle N -> rdData/rdValid at N+1. READ_LATENCY 2: output register added, result at N+2.
- Fully pipelined: one read accepted per cycle; rdValid high one cycle per accepted read.
- rdData holds last value when rdValid = 0.
- Write visible to a different-cycle read issued at N+1 or later.
- clear sampled at N -> busy high N+1 .. N+2**ADDR_WIDTH inclusive; first read accepted at N+2**ADDR_WIDTH+1.
- In-flight reads issued before clear complete normally during busy.
- rst mid-sweep: busy drops immediately (async), state IDLE; addresses below the counter hold CLEAR_VALUE, the rest retain prior contents; in-flight rdValid bits cleared.

## Structure
- Package bram_pkg: ctrl_state_t enum (IDLE, CLEAR), RDW_OLD/RDW_NEW constants.
- Sub-module bram_clear_ctrl: FSM + sweep counter, outputs busy, sweep write enable/address.
- Top bram_sdp: write-port muxing (user vs sweep), masked write loop, RDW forwarding, read pipeline.

## Test plan
(ADDR_WIDTH=4, DATA_WIDTH=16, BYTE_WIDTH=8, CLEAR_VALUE=16'h0000 unless noted)
- Write 16'hBEEF to addr 3, mask 2'b11; read addr 3 next cycle -> rdData 16'hBEEF one cycle later, rdValid single pulse.
- mem[5]=16'h1234; write 16'hABCD mask 2'b01 -> read 5 returns 16'h12CD; mask 2'b00 write -> still 16'h12CD.
- mem[7]=16'h1111; same-cycle write 16'h2222 and read addr 7 -> RDW_MODE 0 returns 16'h1111, RDW_MODE 1 returns 16'h2222.
- Fill all 16 words with 16'hFFFF; pulse clear -> busy high exactly 16 cycles, reads during busy give rdValid 0; afterwards all 16 reads return 16'h0000.
- Fill with 16'hFFFF; clear, assert rst during fifth busy cycle -> busy 0 immediately; addrs 0-3 read 16'h0000, addrs 4-15 read 16'hFFFF.
- READ_LATENCY=2, back-to-back reads addrs 1,2,3 holding 16'h0001/0002/0003 -> data on cycles N+2..N+4 in order, rdValid high three consecutive cycles.
